controle_cronometro: RTL

//  Main sequencer of the stopwatch. Takes one-cycle button pulses from the edge detectors
//  (start/stop, reset, lap) and drives the time-counter datapath.
//  - Generates the counting tick (tick_en) from the system clock.
//  - Issues the counter clear and the display-freeze (lap) control.
//  - Sits between the button edge detectors and the BCD counter/display chain.

---
 rtl/controle_cronometro_pkg.sv | 18 +
 rtl/controle_cronometro_gerador_tick.sv | 42 ++++
 rtl/controle_cronometro.sv | 125 ++++++++++++
 3 files changed

// File: rtl/controle_cronometro_pkg.sv
// Shared definitions for the stopwatch blocks: FSM state encodings and default clock rates.
// Used by controle_cronometro, gerador_tick and the counter/display chain.
package controle_cronometro_pkg;

   localparam logic [1:0] ST_IDLE    = 2'b00;
   localparam logic [1:0] ST_RUNNING = 2'b01;
   localparam logic [1:0] ST_PAUSED  = 2'b10;
   localparam logic [1:0] ST_LAP     = 2'b11;

   localparam int CLK_HZ_DEF  = 50_000_000;
   localparam int TICK_HZ_DEF = 100;

   // Time advances only in RUNNING and LAP; LAP merely freezes the display.
   function automatic logic is_counting(input logic [1:0] st);
      return (st == ST_RUNNING) || (st == ST_LAP);
   endfunction

endpackage

// File: rtl/controle_cronometro_gerador_tick.sv
// gerador_tick: prescaler counting 0..DIV-1 while enabled; registered one-cycle wrap pulse.
// sync_zero restarts the sub-tick phase and wins over enable.
module gerador_tick
   import controle_cronometro_pkg::*;
#(
   parameter int DIV = CLK_HZ_DEF / TICK_HZ_DEF
) (
   input  logic clock,
   input  logic clear,
   input  logic enable,
   input  logic sync_zero,
   output logic wrap
);

   localparam int W = $clog2(DIV);
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] r_cnt;
   logic         r_wrap;

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_cnt  <= '0;
         r_wrap <= 1'b0;
      end else begin
         r_wrap <= 1'b0;
         if (sync_zero) begin
            r_cnt <= '0;
         end else if (enable) begin
            if (r_cnt == LAST) begin
               r_cnt  <= '0;
               r_wrap <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign wrap = r_wrap;

endmodule

// File: rtl/controle_cronometro.sv
// Stopwatch main sequencer: button pulses -> FSM, count tick, counter clear, display hold.
// Lap feature enabled by defining CRONO_LAP_EN; otherwise lap_pls is ignored.
module controle_cronometro
   import controle_cronometro_pkg::*;
#(
   parameter int CLK_HZ  = CLK_HZ_DEF,
   parameter int TICK_HZ = TICK_HZ_DEF
) (
   input  logic       clock,
   input  logic       clear,
   input  logic       start_stop_pls,
   input  logic       reset_pls,
   input  logic       lap_pls,
   output logic       tick_en,
   output logic       counter_clear,
   output logic       display_hold,
   output logic       running,
   output logic [1:0] state_out
);

   localparam int DIV = CLK_HZ / TICK_HZ;

   logic [1:0] r_state;
   logic [1:0] w_next_state;
   logic       r_hold;
   logic       w_next_hold;
   logic       w_do_clear;
   logic       r_clr;
   logic       r_run;
   logic       w_lap;
   logic       w_count_en;
   logic       w_tick;

`ifdef CRONO_LAP_EN
   assign w_lap = lap_pls;
`else
   logic w_lap_unused;
   assign w_lap_unused = lap_pls;
   assign w_lap        = 1'b0;
`endif

   // Priority reset > start_stop > lap falls out of the if/else order in each state.
   always_comb begin
      w_next_state = r_state;
      w_next_hold  = r_hold;
      w_do_clear   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (reset_pls) begin
               w_do_clear  = 1'b1;
               w_next_hold = 1'b0;
            end else if (start_stop_pls) begin
               w_next_state = ST_RUNNING;
            end
         end
         ST_RUNNING: begin
            if (start_stop_pls) begin
               w_next_state = ST_PAUSED;
               w_next_hold  = 1'b0;
            end else if (w_lap) begin
               w_next_state = ST_LAP;
               w_next_hold  = 1'b1;
            end
         end
         ST_LAP: begin
            if (start_stop_pls) begin
               w_next_state = ST_PAUSED;
            end else if (w_lap) begin
               w_next_state = ST_RUNNING;
               w_next_hold  = 1'b0;
            end
         end
         ST_PAUSED: begin
            if (reset_pls) begin
               w_next_state = ST_IDLE;
               w_next_hold  = 1'b0;
               w_do_clear   = 1'b1;
            end else if (start_stop_pls) begin
               w_next_state = r_hold ? ST_LAP : ST_RUNNING;
            end else if (w_lap) begin
               w_next_hold = 1'b0;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
            w_next_hold  = 1'b0;
         end
      endcase
   end

   // Count only on edges that stay inside the counting states, so the first tick lands
   // DIV cycles after entering RUNNING and a resume keeps the stored phase.
   assign w_count_en = is_counting(r_state) && is_counting(w_next_state);

   gerador_tick #(
      .DIV(DIV)
   ) u_gerador_tick (
      .clock    (clock),
      .clear    (clear),
      .enable   (w_count_en),
      .sync_zero(w_do_clear),
      .wrap     (w_tick)
   );

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_state <= ST_IDLE;
         r_hold  <= 1'b0;
         r_clr   <= 1'b0;
         r_run   <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_hold  <= w_next_hold;
         r_clr   <= w_do_clear;
         r_run   <= is_counting(w_next_state);
      end
   end

   assign tick_en       = w_tick;
   assign counter_clear = r_clr;
   assign display_hold  = r_hold;
   assign running       = r_run;
   assign state_out     = r_state;

endmodule
